// File: rtl/sample_dma_pkg.sv
// Shared constants for sample_dma: register offsets, bit positions and engine states.
package sample_dma_pkg;

    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_BASE   = 5'h04;
    localparam logic [4:0] REG_SIZE   = 5'h08;
    localparam logic [4:0] REG_WPTR   = 5'h0C;
    localparam logic [4:0] REG_STATUS = 5'h10;
    localparam logic [4:0] REG_COUNT  = 5'h14;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_RING   = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_WRAPPED = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/sample_dma.sv
// Drains the sample FIFO into an SDRAM ring/linear buffer; CPU-visible register window included.
//   state | meaning
//   IDLE  | no write outstanding; pops the FIFO when enabled, not full and data present
//   WRITE | wvalid held with stable address/data until wready; may chain the next word
module sample_dma
    import sample_dma_pkg::*;
#(
    parameter int AW = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    output logic          fifo_rd,
    output logic [AW-1:0] awaddr,
    output logic [DW-1:0] wdata,
    output logic          wvalid,
    input  logic          wready,
    input  logic [4:0]    waddr,
    input  logic [31:0]   wdata_reg,
    input  logic          wvalid_reg,
    input  logic [4:0]    araddr,
    input  logic          arvalid,
    output logic [31:0]   rdata,
    output logic          rvalid
);

    state_t        state, state_nxt;
    logic          enable, ring, clear_pend, full, wrapped;
    logic [AW-1:0] base, size, wptr;
    logic [31:0]   count;

    logic          ctrl_wr, clr_wr, hs, load;
    logic [AW:0]   nxt;
    logic [AW-1:0] wptr_adv, ptr_sel;
    logic          full_adv, wrapped_adv;
    logic [31:0]   count_adv;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign unused_wdata = ^wdata_reg[31:AW];
    assign ctrl_wr      = wvalid_reg && (waddr == REG_CTRL);
    assign clr_wr       = ctrl_wr && wdata_reg[CTRL_CLEAR];
    assign hs           = (state == WRITE) && wready;
    assign fifo_rd      = load;

    // Pointer/status update applied at a handshake; a pending clear replaces the advance.
    always_comb begin
        wptr_adv    = wptr;
        full_adv    = full;
        wrapped_adv = wrapped;
        count_adv   = count;
        nxt         = {1'b0, wptr} + (AW+1)'(1);
        if (clear_pend || clr_wr) begin
            wptr_adv    = '0;
            full_adv    = 1'b0;
            wrapped_adv = 1'b0;
            count_adv   = '0;
        end else begin
            if (count != '1)
                count_adv = count + 32'd1;
            if (nxt >= {1'b0, size}) begin
                if (ring) begin
                    wptr_adv    = '0;
                    wrapped_adv = 1'b1;
                end else begin
                    wptr_adv = size;
                    full_adv = 1'b1;
                end
            end else begin
                wptr_adv = nxt[AW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ptr_sel   = wptr;
        case (state)
            IDLE: begin
                if (enable && !full && (size != '0) && !fifo_empty && !clr_wr) begin
                    load      = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (hs) begin
                    ptr_sel = wptr_adv;
                    if (enable && !full_adv && (size != '0) && !fifo_empty)
                        load = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvalid     <= 1'b0;
            awaddr     <= '0;
            wdata      <= '0;
            enable     <= 1'b0;
            ring       <= 1'b0;
            clear_pend <= 1'b0;
            full       <= 1'b0;
            wrapped    <= 1'b0;
            base       <= '0;
            size       <= '0;
            wptr       <= '0;
            count      <= '0;
        end else begin
            wvalid <= (state_nxt == WRITE);
            if (load) begin
                wdata  <= fifo_dout;
                awaddr <= base + ptr_sel;
            end
            if (hs) begin
                wptr       <= wptr_adv;
                full       <= full_adv;
                wrapped    <= wrapped_adv;
                count      <= count_adv;
                clear_pend <= 1'b0;
            end else if (clr_wr) begin
                if (state == IDLE) begin
                    wptr    <= '0;
                    full    <= 1'b0;
                    wrapped <= 1'b0;
                    count   <= '0;
                end else begin
                    clear_pend <= 1'b1;
                end
            end
            if (ctrl_wr) begin
                enable <= wdata_reg[CTRL_ENABLE];
                ring   <= wdata_reg[CTRL_RING];
            end
            if (wvalid_reg && (waddr == REG_BASE))
                base <= wdata_reg[AW-1:0];
            if (wvalid_reg && (waddr == REG_SIZE))
                size <= wdata_reg[AW-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (araddr)
            REG_CTRL: begin
                rd_mux[CTRL_ENABLE] = enable;
                rd_mux[CTRL_RING]   = ring;
            end
            REG_BASE:  rd_mux = 32'(base);
            REG_SIZE:  rd_mux = 32'(size);
            REG_WPTR:  rd_mux = 32'(wptr);
            REG_STATUS: begin
                rd_mux[STAT_BUSY]    = (state != IDLE);
                rd_mux[STAT_FULL]    = full;
                rd_mux[STAT_WRAPPED] = wrapped;
            end
            REG_COUNT: rd_mux = count;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= arvalid;
            if (arvalid)
                rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sample_dma.sv
// Self-checking bench for sample_dma: FIFO/SDRAM models, vector table, corner sequences, random rounds.
module tb_sample_dma;
    import sample_dma_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty, fifo_rd;
    logic [AW-1:0] awaddr;
    logic [DW-1:0] wdata;
    logic          wvalid, wready;
    logic [4:0]    waddr, araddr;
    logic [31:0]   wdata_reg, rdata;
    logic          wvalid_reg, arvalid, rvalid;

    sample_dma #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .awaddr(awaddr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .waddr(waddr), .wdata_reg(wdata_reg), .wvalid_reg(wvalid_reg),
        .araddr(araddr), .arvalid(arvalid), .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    // first-word-fall-through FIFO model
    logic [15:0] mem [64];
    int   wr_ptr = 0, rd_ptr = 0;
    logic flush_req = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr % 64];
    always @(posedge clk)
        if (flush_req) rd_ptr <= wr_ptr;
        else if (fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;

    int pops = 0, underflows = 0;
    always @(posedge clk) begin
        if (fifo_rd) pops <= pops + 1;
        if (fifo_rd && fifo_empty) underflows <= underflows + 1;
    end

    // wready: 0 = always ready, 1 = random, 2 = stalled
    int wr_mode = 0;
    always @(negedge clk)
        case (wr_mode)
            0:       wready = 1'b1;
            1:       wready = 1'($urandom_range(0, 1));
            default: wready = 1'b0;
        endcase

    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    always @(posedge clk)
        if (rst_n && wvalid && wready) begin
            log_addr.push_back(awaddr);
            log_data.push_back(wdata);
        end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        waddr = a; wdata_reg = d; wvalid_reg = 1'b1;
        @(negedge clk);
        wvalid_reg = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        d = rdata;
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic wait_idle();
        int idle = 0;
        int t = 0;
        while (idle < 3 && t < 3000) begin
            @(negedge clk);
            t++;
            if (wvalid) idle = 0; else idle++;
        end
        check("idle_reached", 32'(idle >= 3), 32'd1);
    endtask

    task automatic wait_wvalid();
        int t = 0;
        while (!wvalid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wvalid_seen", 32'(wvalid), 32'd1);
    endtask

    function automatic logic [31:0] ctrl(input bit en, input bit rg, input bit clr);
        return {29'd0, clr, rg, en};
    endfunction

    task automatic setup(input logic [23:0] b, input logic [23:0] s, input bit rg);
        reg_write(REG_CTRL, 32'd0);
        wait_idle();
        @(negedge clk); flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
        reg_write(REG_BASE, 32'(b));
        reg_write(REG_SIZE, 32'(s));
        reg_write(REG_CTRL, ctrl(1'b0, rg, 1'b1));
    endtask

    typedef struct {
        logic [23:0] base;
        logic [23:0] size;
        bit          ring;
        bit          cont;
        int          npush;
        int          exp_nwr;
        logic [23:0] exp_last;
        logic [31:0] exp_wptr;
        logic [31:0] exp_status;
        logic [31:0] exp_count;
        int          exp_left;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] rd;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        int start, nwr, p0, stable;
        logic [4:0] offs [6];

        tbl[0] = '{24'h000100, 24'd4, 1'b0, 1'b0, 3, 3, 24'h000102, 32'd3, 32'h0, 32'd3, 0};
        tbl[1] = '{24'h000100, 24'd4, 1'b0, 1'b1, 3, 1, 24'h000103, 32'd4, 32'h2, 32'd4, 2};
        tbl[2] = '{24'h000100, 24'd2, 1'b1, 1'b0, 5, 5, 24'h000100, 32'd1, 32'h4, 32'd5, 0};
        tbl[3] = '{24'hFFFFFE, 24'd4, 1'b0, 1'b0, 3, 3, 24'h000000, 32'd3, 32'h0, 32'd3, 0};
        tbl[4] = '{24'h000300, 24'd0, 1'b0, 1'b0, 2, 0, 24'h000000, 32'd0, 32'h0, 32'd0, 2};
        tbl[5] = '{24'h123456, 24'd1, 1'b1, 1'b0, 3, 3, 24'h123456, 32'd0, 32'h4, 32'd3, 0};
        offs = '{REG_CTRL, REG_BASE, REG_SIZE, REG_WPTR, REG_STATUS, REG_COUNT};

        waddr = '0; wdata_reg = '0; wvalid_reg = 1'b0; araddr = '0; arvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_wvalid",  32'(wvalid),  32'd0);
        check("rst_awaddr",  32'(awaddr),  32'd0);
        check("rst_wdata",   32'(wdata),   32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            reg_read(offs[i], rd);
            check($sformatf("rst_reg_%0h", offs[i]), rd, 32'd0);
        end

        // vector table
        for (int i = 0; i < 6; i++) begin
            if (!tbl[i].cont) setup(tbl[i].base, tbl[i].size, tbl[i].ring);
            start = log_addr.size();
            for (int j = 0; j < tbl[i].npush; j++) push(16'(16'hA1 + 16 * i + j));
            if (!tbl[i].cont) reg_write(REG_CTRL, ctrl(1'b1, tbl[i].ring, 1'b0));
            wait_idle();
            nwr = log_addr.size() - start;
            check($sformatf("v%0d_nwr", i), 32'(nwr), 32'(tbl[i].exp_nwr));
            if (tbl[i].exp_nwr > 0 && nwr > 0)
                check($sformatf("v%0d_last_addr", i), 32'(log_addr[log_addr.size()-1]), 32'(tbl[i].exp_last));
            for (int k = 0; k < nwr && k < tbl[i].exp_nwr; k++)
                check($sformatf("v%0d_data%0d", i, k), 32'(log_data[start+k]), 32'(16'hA1 + 16 * i + k));
            reg_read(REG_WPTR, rd);   check($sformatf("v%0d_wptr", i), rd, tbl[i].exp_wptr);
            reg_read(REG_STATUS, rd); check($sformatf("v%0d_status", i), rd, tbl[i].exp_status);
            reg_read(REG_COUNT, rd);  check($sformatf("v%0d_count", i), rd, tbl[i].exp_count);
            check($sformatf("v%0d_left", i), 32'(wr_ptr - rd_ptr), 32'(tbl[i].exp_left));
        end

        // long wready stall
        setup(24'h000200, 24'd8, 1'b0);
        wr_mode = 2;
        push(16'hBEEF);
        reg_write(REG_CTRL, ctrl(1'b1, 1'b0, 1'b0));
        wait_wvalid();
        a0 = awaddr; d0 = wdata; p0 = pops; stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (wvalid !== 1'b1 || awaddr !== a0 || wdata !== d0) stable = 0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_addr", 32'(a0), 32'h200);
        check("stall_data", 32'(d0), 32'hBEEF);
        reg_read(REG_COUNT, rd); check("stall_count_before", rd, 32'd0);
        wr_mode = 0;
        wait_idle();
        reg_read(REG_COUNT, rd); check("stall_count_after", rd, 32'd1);
        check("stall_no_extra_pop", 32'(pops - p0), 32'd0);

        // clear while a write is outstanding
        push(16'h0001); push(16'h0002);
        wait_idle();
        reg_read(REG_COUNT, rd); check("pre_clear_count", rd, 32'd3);
        wr_mode = 2;
        push(16'h1111);
        wait_wvalid();
        reg_write(REG_CTRL, ctrl(1'b1, 1'b0, 1'b1));
        repeat (3) @(negedge clk);
        wr_mode = 0;
        wait_idle();
        reg_read(REG_WPTR, rd);   check("clr_wptr", rd, 32'd0);
        reg_read(REG_COUNT, rd);  check("clr_count", rd, 32'd0);
        reg_read(REG_STATUS, rd); check("clr_status", rd, 32'd0);
        start = log_addr.size();
        push(16'h2222);
        wait_idle();
        check("clr_next_written", 32'(log_addr.size() > start), 32'd1);
        if (log_addr.size() > start) check("clr_next_addr", 32'(log_addr[start]), 32'h200);
        reg_read(REG_COUNT, rd); check("clr_next_count", rd, 32'd1);

        // asynchronous reset in the middle of a write
        wr_mode = 2;
        push(16'h3333);
        wait_wvalid();
        #2 rst_n = 1'b0;
        #1;
        check("arst_wvalid",  32'(wvalid),  32'd0);
        check("arst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("arst_awaddr",  32'(awaddr),  32'd0);
        check("arst_wdata",   32'(wdata),   32'd0);
        @(negedge clk); rst_n = 1'b1; wr_mode = 0;
        @(negedge clk);
        araddr = REG_STATUS; arvalid = 1'b1;
        #1 check("arst_rvalid_pre", 32'(rvalid), 32'd0);
        @(posedge clk); #1;
        check("arst_rvalid_1", 32'(rvalid), 32'd1);
        check("arst_status", rdata, 32'd0);
        @(negedge clk); arvalid = 1'b0;
        @(posedge clk); #1;
        check("arst_rvalid_off", 32'(rvalid), 32'd0);
        reg_read(REG_BASE, rd);  check("arst_base", rd, 32'd0);
        reg_read(REG_COUNT, rd); check("arst_count", rd, 32'd0);

        // randomized rounds against a word-by-word buffer model
        for (int r = 0; r < 25; r++) begin
            logic [23:0] b, s, mw;
            bit rg, mfull, mwrap;
            int n, mcount, mleft, nexp;
            logic [15:0] dq [16];
            logic [23:0] ea [16];
            b  = ($urandom_range(0, 3) == 0) ? 24'(24'hFFFFFF - $urandom_range(0, 3)) : 24'($urandom);
            s  = 24'($urandom_range(0, 6));
            rg = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 9);
            setup(b, s, rg);
            for (int k = 0; k < n; k++) begin
                dq[k] = 16'($urandom);
                push(dq[k]);
            end
            wr_mode = 1;
            start = log_addr.size();
            reg_write(REG_CTRL, ctrl(1'b1, rg, 1'b0));
            wait_idle();
            wr_mode = 0;
            mw = 0; mfull = 0; mwrap = 0; mcount = 0; mleft = 0; nexp = 0;
            for (int k = 0; k < n; k++) begin
                if (!mfull && s != 0) begin
                    ea[nexp] = 24'((int'(b) + int'(mw)) % (1 << 24));
                    nexp++;
                    mcount++;
                    mw = mw + 1;
                    if (mw >= s) begin
                        if (rg) begin mw = 0; mwrap = 1; end
                        else    begin mw = s; mfull = 1; end
                    end
                end else begin
                    mleft++;
                end
            end
            nwr = log_addr.size() - start;
            check($sformatf("r%0d_nwr", r), 32'(nwr), 32'(nexp));
            for (int k = 0; k < nwr && k < nexp; k++) begin
                check($sformatf("r%0d_addr%0d", r, k), 32'(log_addr[start+k]), 32'(ea[k]));
                check($sformatf("r%0d_data%0d", r, k), 32'(log_data[start+k]), 32'(dq[k]));
            end
            reg_read(REG_WPTR, rd);   check($sformatf("r%0d_wptr", r), rd, 32'(mw));
            reg_read(REG_STATUS, rd); check($sformatf("r%0d_status", r), rd, {29'd0, mwrap, mfull, 1'b0});
            reg_read(REG_COUNT, rd);  check($sformatf("r%0d_count", r), rd, 32'(mcount));
            check($sformatf("r%0d_left", r), 32'(wr_ptr - rd_ptr), 32'(mleft));
        end

        check("no_pop_when_empty", 32'(underflows), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
